// File: rtl/pc_pkg.sv
// Shared opcode encoding and sizing helpers for the program-counter sequencer.
`default_nettype none

package pc_pkg;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        INC    = 3'd1,
        BRANCH = 3'd2,
        JUMP   = 3'd3,
        CALL   = 3'd4,
        RET    = 3'd5
    } pc_op_t;

    localparam int DEFAULT_STACK_DEPTH = 4;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEFAULT_LEVEL_W = level_width(DEFAULT_STACK_DEPTH);

    // Offset is sign-extended from bit (width-1); callers keep only the low width bits.
    function automatic logic [15:0] offset_add(input logic [15:0] base,
                                               input logic [15:0] offset,
                                               input int          width);
        logic [15:0] ext;
        ext = offset;
        for (int i = 0; i < 16; i++) begin
            if (i >= width) ext[i] = offset[width-1];
        end
        return base + ext;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_if.sv
// Control/datapath-facing bundle of the program-counter sequencer.
`default_nettype none

interface pc_sequencer_if
    import pc_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int LEVEL_W = DEFAULT_LEVEL_W
);
    logic              en;
    logic [2:0]        op;
    logic              cond;
    logic [DATA_W-1:0] C;
    logic              msel;
    logic [ADDR_W-1:0] address;
    logic [ADDR_W-1:0] pc;
    logic [LEVEL_W-1:0] stack_level;
    logic              stack_full;
    logic              stack_empty;
    logic              overflow_err;
    logic              underflow_err;

    modport master (
        output en, op, cond, C, msel,
        input  address, pc, stack_level, stack_full, stack_empty,
               overflow_err, underflow_err
    );

    modport slave (
        input  en, op, cond, C, msel,
        output address, pc, stack_level, stack_full, stack_empty,
               overflow_err, underflow_err
    );
endinterface

`default_nettype wire

// File: rtl/pc_return_stack.sv
// Bounded LIFO of return addresses; refuses push when full and pop when empty.
`default_nettype none

module pc_return_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int LEVEL_W     = level_width(STACK_DEPTH)
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               push,
    input  wire logic               pop,
    input  wire logic [ADDR_W-1:0]  push_data,
    output      logic [ADDR_W-1:0]  top_data,
    output      logic [LEVEL_W-1:0] level,
    output      logic               full,
    output      logic               empty,
    output      logic               push_err,
    output      logic               pop_err
);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic              push_ok;
    logic              pop_ok;

    assign full     = (level == LEVEL_W'(STACK_DEPTH));
    assign empty    = (level == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign push_err = push && full;
    assign pop_err  = pop && empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= '0;
        end else if (push_ok) begin
            level <= level + 1'b1;
        end else if (pop_ok) begin
            level <= level - 1'b1;
        end
    end

    // Entry contents need no reset; only the level defines what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push_ok && (level == LEVEL_W'(i))) mem[i] <= push_data;
        end
    end

    always_comb begin
        top_data = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (level == LEVEL_W'(i + 1)) top_data = mem[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, PC register, sticky stack errors
// and the PC-or-datapath memory address mux.
`default_nettype none

module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              ADDR_W      = 8,
    parameter int              DATA_W      = 16,
    parameter int              STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  wire logic clk,
    input  wire logic reset,
    pc_sequencer_if.slave bus
);

    localparam int LEVEL_W = level_width(STACK_DEPTH);

    logic [ADDR_W-1:0]  pc_reg;
    logic [ADDR_W-1:0]  next_pc;
    logic [ADDR_W-1:0]  pc_plus1;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  branch_pc;
    logic [ADDR_W-1:0]  top_data;
    logic [LEVEL_W-1:0] level;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               push_err;
    logic               pop_err;
    logic               overflow_reg;
    logic               underflow_reg;

    assign pc_plus1  = pc_reg + 1'b1;
    assign target    = bus.C[ADDR_W-1:0];
    assign branch_pc = ADDR_W'(offset_add(16'(pc_reg), 16'(target), ADDR_W));

    // push/pop are gated by en, so a held cycle can never touch the stack or flags.
    always_comb begin
        next_pc = pc_reg;
        push    = 1'b0;
        pop     = 1'b0;
        if (bus.en) begin
            case (bus.op)
                INC:     next_pc = pc_plus1;
                BRANCH:  next_pc = bus.cond ? branch_pc : pc_plus1;
                JUMP:    next_pc = target;
                CALL: begin
                    push    = 1'b1;
                    next_pc = full ? pc_plus1 : target;
                end
                RET: begin
                    pop     = 1'b1;
                    next_pc = empty ? pc_plus1 : top_data;
                end
                default: next_pc = pc_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg        <= RESET_PC;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            pc_reg <= next_pc;
            if (push_err) overflow_reg  <= 1'b1;
            if (pop_err)  underflow_reg <= 1'b1;
        end
    end

    pc_return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH),
        .LEVEL_W     (LEVEL_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus1),
        .top_data  (top_data),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .push_err  (push_err),
        .pop_err   (pop_err)
    );

    assign bus.address       = bus.msel ? target : pc_reg;
    assign bus.pc            = pc_reg;
    assign bus.stack_level   = level;
    assign bus.stack_full    = full;
    assign bus.stack_empty   = empty;
    assign bus.overflow_err  = overflow_reg;
    assign bus.underflow_err = underflow_reg;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer against a queue-based behavioural model.
`default_nettype none

module tb_pc_sequencer;
    import pc_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int DEPTH = 4;
    localparam int LW = 3;
    localparam logic [7:0] RPC = 8'h10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(AW), .DATA_W(DW), .LEVEL_W(LW)) bus ();

    pc_sequencer #(.ADDR_W(AW), .DATA_W(DW), .STACK_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    int m_pc;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;

    function automatic void model_reset();
        m_pc = RPC;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic void model_op(bit e, int o, bit cnd, int c);
        int tgt;
        int s;
        if (!e) return;
        tgt = c & 255;
        case (o)
            1: m_pc = (m_pc + 1) % 256;
            2: begin
                s = (tgt >= 128) ? tgt - 256 : tgt;
                m_pc = cnd ? (m_pc + s + 256) % 256 : (m_pc + 1) % 256;
            end
            3: m_pc = tgt;
            4: begin
                if (m_stk.size() < DEPTH) begin
                    m_stk.push_back((m_pc + 1) % 256);
                    m_pc = tgt;
                end else begin
                    m_ovf = 1'b1;
                    m_pc = (m_pc + 1) % 256;
                end
            end
            5: begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin
                    m_unf = 1'b1;
                    m_pc = (m_pc + 1) % 256;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic step(input bit e, input int o, input bit cnd, input int c);
        bus.en = e;
        bus.op = o[2:0];
        bus.cond = cnd;
        bus.C = c[15:0];
        model_op(e, o, cnd, c);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.en = 1'b0;
        bus.op = 3'd0;
        bus.msel = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.op = 3'd0; bus.cond = 1'b0; bus.C = '0; bus.msel = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.pc !== 8'h10) begin failures++; $display("FAIL reset_pc got=%h exp=10", bus.pc); end
        checks++; if (bus.stack_level !== 3'd0 || bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0)
            begin failures++; $display("FAIL reset_stack got lvl=%0d e=%b f=%b exp lvl=0 e=1 f=0", bus.stack_level, bus.stack_empty, bus.stack_full); end
        checks++; if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0)
            begin failures++; $display("FAIL reset_flags got ovf=%b unf=%b exp 0 0", bus.overflow_err, bus.underflow_err); end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step(1, INC, 0, 0);
        checks++; if (bus.pc !== 8'h13) begin failures++; $display("FAIL reset_inc3 got=%h exp=13", bus.pc); end
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.pc !== 8'h10) begin failures++; $display("FAIL async_reset got=%h exp=10", bus.pc); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_inc_wrap();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'hFF; exp_seq[1] = 8'h00; exp_seq[2] = 8'h01;
        step(1, JUMP, 0, 16'h00FE);
        for (int i = 0; i < 3; i++) begin
            step(1, INC, 0, 0);
            checks++; if (bus.pc !== exp_seq[i] || bus.pc !== 8'(m_pc))
                begin failures++; $display("FAIL inc_wrap[%0d] got=%h exp=%h", i, bus.pc, exp_seq[i]); end
        end
    endtask

    task automatic test_branch();
        step(1, JUMP, 0, 16'h0010);
        step(1, BRANCH, 1, 16'h00F0);
        checks++; if (bus.pc !== 8'h00) begin failures++; $display("FAIL branch_taken got=%h exp=00", bus.pc); end
        step(1, JUMP, 0, 16'h0010);
        step(1, BRANCH, 0, 16'h00F0);
        checks++; if (bus.pc !== 8'h11) begin failures++; $display("FAIL branch_not_taken got=%h exp=11", bus.pc); end
        step(1, BRANCH, 1, 16'hAB80);
        checks++; if (bus.pc !== 8'(m_pc)) begin failures++; $display("FAIL branch_neg128 got=%h exp=%h", bus.pc, 8'(m_pc)); end
    endtask

    task automatic test_call_ret();
        step(1, JUMP, 0, 16'h0020);
        step(1, CALL, 0, 16'h0040);
        checks++; if (bus.pc !== 8'h40 || bus.stack_level !== 3'd1)
            begin failures++; $display("FAIL call got pc=%h lvl=%0d exp pc=40 lvl=1", bus.pc, bus.stack_level); end
        step(1, INC, 0, 0);
        step(1, RET, 0, 0);
        checks++; if (bus.pc !== 8'h21 || bus.stack_empty !== 1'b1)
            begin failures++; $display("FAIL ret got pc=%h empty=%b exp pc=21 empty=1", bus.pc, bus.stack_empty); end
    endtask

    task automatic test_overflow_underflow();
        logic [7:0] ret_seq [4];
        ret_seq[0] = 8'h51; ret_seq[1] = 8'h41; ret_seq[2] = 8'h31; ret_seq[3] = 8'h01;
        apply_reset();
        step(1, JUMP, 0, 16'h0000);
        for (int i = 0; i < 4; i++) step(1, CALL, 0, 16'h0030 + 16'(i) * 16'h10);
        checks++; if (bus.stack_level !== 3'd4 || bus.stack_full !== 1'b1 || bus.overflow_err !== 1'b0)
            begin failures++; $display("FAIL fill got lvl=%0d full=%b ovf=%b exp 4 1 0", bus.stack_level, bus.stack_full, bus.overflow_err); end
        step(1, CALL, 0, 16'h0070);
        checks++; if (bus.pc !== 8'h61 || bus.overflow_err !== 1'b1 || bus.stack_level !== 3'd4)
            begin failures++; $display("FAIL overflow got pc=%h ovf=%b lvl=%0d exp 61 1 4", bus.pc, bus.overflow_err, bus.stack_level); end
        for (int i = 0; i < 4; i++) begin
            step(1, RET, 0, 0);
            checks++; if (bus.pc !== ret_seq[i] || bus.stack_level !== 3'(3 - i))
                begin failures++; $display("FAIL unwind[%0d] got pc=%h lvl=%0d exp pc=%h lvl=%0d", i, bus.pc, bus.stack_level, ret_seq[i], 3 - i); end
        end
        step(1, RET, 0, 0);
        checks++; if (bus.pc !== 8'h02 || bus.underflow_err !== 1'b1 || bus.stack_empty !== 1'b1)
            begin failures++; $display("FAIL underflow got pc=%h unf=%b empty=%b exp 02 1 1", bus.pc, bus.underflow_err, bus.stack_empty); end
    endtask

    task automatic test_enable_hold();
        logic [7:0] pc0;
        logic [2:0] lvl0;
        step(1, CALL, 0, 16'h0090);
        pc0 = bus.pc;
        lvl0 = bus.stack_level;
        bus.msel = 1'b1;
        for (int i = 0; i < 3; i++) step(0, JUMP, 1, 16'h0055);
        checks++; if (bus.pc !== pc0 || bus.pc !== 8'(m_pc) || bus.stack_level !== lvl0)
            begin failures++; $display("FAIL en_hold got pc=%h lvl=%0d exp pc=%h lvl=%0d", bus.pc, bus.stack_level, pc0, lvl0); end
        checks++; if (bus.overflow_err !== m_ovf || bus.underflow_err !== m_unf)
            begin failures++; $display("FAIL en_hold_flags got ovf=%b unf=%b exp %b %b", bus.overflow_err, bus.underflow_err, m_ovf, m_unf); end
        checks++; if (bus.address !== 8'h55) begin failures++; $display("FAIL addr_msel1 got=%h exp=55", bus.address); end
        bus.msel = 1'b0;
        #1;
        checks++; if (bus.address !== 8'(m_pc)) begin failures++; $display("FAIL addr_msel0 got=%h exp=%h", bus.address, 8'(m_pc)); end
    endtask

    task automatic test_reserved();
        apply_reset();
        step(1, JUMP, 0, 16'h0077);
        step(1, 6, 1, 16'h0033);
        step(1, 7, 1, 16'h0033);
        checks++; if (bus.pc !== 8'h77 || bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0 || bus.stack_level !== 3'd0)
            begin failures++; $display("FAIL reserved got pc=%h ovf=%b unf=%b lvl=%0d exp 77 0 0 0", bus.pc, bus.overflow_err, bus.underflow_err, bus.stack_level); end
    endtask

    task automatic test_back_to_back();
        step(1, JUMP, 0, 16'h0033);
        step(1, CALL, 0, 16'h0080);
        step(1, RET, 0, 0);
        checks++; if (bus.pc !== 8'h34 || bus.stack_empty !== 1'b1)
            begin failures++; $display("FAIL b2b_call_ret got pc=%h empty=%b exp 34 1", bus.pc, bus.stack_empty); end
        step(1, JUMP, 0, 16'h00FF);
        step(1, CALL, 0, 16'h0010);
        step(1, RET, 0, 0);
        checks++; if (bus.pc !== 8'h00) begin failures++; $display("FAIL call_wrap_ret got=%h exp=00", bus.pc); end
    endtask

    task automatic test_random();
        int o;
        int c;
        bit e;
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            o = int'($urandom_range(0, 7));
            e = ($urandom_range(0, 9) != 0);
            c = int'($urandom_range(0, 65535));
            bus.msel = 1'($urandom_range(0, 1));
            step(e, o, 1'($urandom_range(0, 1)), c);
            checks++;
            if (bus.pc !== 8'(m_pc) || bus.stack_level !== 3'(m_stk.size()) ||
                bus.stack_full !== (m_stk.size() == DEPTH) || bus.stack_empty !== (m_stk.size() == 0) ||
                bus.overflow_err !== m_ovf || bus.underflow_err !== m_unf ||
                bus.address !== (bus.msel ? 8'(c & 255) : 8'(m_pc))) begin
                failures++;
                $display("FAIL random[%0d] op=%0d en=%b got pc=%h lvl=%0d ovf=%b unf=%b addr=%h exp pc=%h lvl=%0d ovf=%b unf=%b",
                         n, o, e, bus.pc, bus.stack_level, bus.overflow_err, bus.underflow_err, bus.address,
                         8'(m_pc), m_stk.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_inc_wrap();
        test_branch();
        test_call_ret();
        test_overflow_underflow();
        test_enable_hold();
        test_reserved();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
